// File: rtl/pio128_rd_ctrl.sv
// pio128_rd_ctrl: FIFO-backed read controller for a 128-bit Avalon PIO input port.
// Presents {1,payload} words (or a zero sentinel after a stalled-read timeout) with a one-cycle setup before release.
`default_nettype none

module pio128_rd_ctrl #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [126:0]             in_data,
  input  logic                     flush,
  input  logic                     read_request,
  output logic                     block_read,
  output logic [127:0]             pio_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     timeout_pulse
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    OFFER  = 3'd2,
    ESETUP = 3'd3,
    EOFFER = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           block_read_q, block_read_d;
  logic [127:0]   pio_data_q, pio_data_d;
  logic           timeout_pulse_q, timeout_pulse_d;

  logic [126:0]   mem [DEPTH];
  logic [126:0]   head;
  logic [AW:0]    level;
  logic           push;
  logic           pop;
  logic           empty;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign level    = wr_ptr_q - rd_ptr_q;
  assign empty    = (level == '0);
  assign in_ready = (level != FULL_LVL);
  assign push     = in_valid && in_ready && !flush;
  assign pop      = (state_q == OFFER) && read_request && !flush;
  assign head     = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    timer_d         = timer_q;
    block_read_d    = block_read_q;
    pio_data_d      = pio_data_q;
    timeout_pulse_d = 1'b0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        block_read_d = 1'b1;
        if (!empty) begin
          pio_data_d = {1'b1, head};
          state_d    = SETUP;
          timer_d    = '0;
        end else if (push) begin
          // A word is on its way, so the stalled read will be served by data.
          timer_d = '0;
        end else if (read_request) begin
          if (timer_q == TMAX) begin
            pio_data_d = '0;
            state_d    = ESETUP;
            timer_d    = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end else begin
          timer_d = '0;
        end
      end
      SETUP: begin
        block_read_d = 1'b0;
        state_d      = OFFER;
      end
      OFFER: begin
        if (pop) begin
          rd_ptr_d     = rd_ptr_q + 1'b1;
          block_read_d = 1'b1;
          state_d      = IDLE;
        end
      end
      ESETUP: begin
        block_read_d = 1'b0;
        state_d      = EOFFER;
      end
      EOFFER: begin
        if (read_request) begin
          timeout_pulse_d = 1'b1;
          block_read_d    = 1'b1;
          state_d         = IDLE;
        end
      end
      default: begin
        block_read_d = 1'b1;
        state_d      = IDLE;
      end
    endcase

    if (flush) begin
      state_d         = IDLE;
      wr_ptr_d        = '0;
      rd_ptr_d        = '0;
      timer_d         = '0;
      block_read_d    = 1'b1;
      pio_data_d      = '0;
      timeout_pulse_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      timer_q         <= '0;
      block_read_q    <= 1'b1;
      pio_data_q      <= '0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      timer_q         <= timer_d;
      block_read_q    <= block_read_d;
      pio_data_q      <= pio_data_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  assign block_read    = block_read_q;
  assign pio_data      = pio_data_q;
  assign fifo_level    = level;
  assign timeout_pulse = timeout_pulse_q;

endmodule

`default_nettype wire
